game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 162 ++++++++++++++++
 tb/tb_game_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// 2x2 sliding-tile puzzle controller: board selection, validation, move handling,
// win detection and best-score tracking.
module game_controller (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [11:0] board_in,
    input  logic        confirm,
    input  logic        abort,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic [1:0]  game_status,
    output logic [11:0] board,
    output logic [9:0]  move_count,
    output logic [9:0]  best_moves,
    output logic        illegal,
    output logic        board_err
);

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } state_t;

    localparam logic [11:0] GOAL     = 12'b000_001_010_011;
    localparam logic [9:0]  NO_BEST  = 10'h3FF;
    localparam logic [9:0]  MAX_CNT  = 10'h3FF;

    state_t      state_q, state_d;
    logic [11:0] board_d;
    logic [9:0]  count_d, best_d, count_inc;
    logic        illegal_d, err_d;

    logic [1:0]  blank, target;
    logic        legal, perm_ok;
    logic [3:0]  seen;
    logic        all_small;
    logic [11:0] moved;

    function automatic logic [2:0] get_slot(input logic [11:0] b, input logic [1:0] p);
        case (p)
            2'd0:    return b[11:9];
            2'd1:    return b[8:6];
            2'd2:    return b[5:3];
            default: return b[2:0];
        endcase
    endfunction

    function automatic logic [11:0] set_slot(input logic [11:0] b, input logic [1:0] p,
                                             input logic [2:0] v);
        logic [11:0] r;
        r = b;
        case (p)
            2'd0:    r[11:9] = v;
            2'd1:    r[8:6]  = v;
            2'd2:    r[5:3]  = v;
            default: r[2:0]  = v;
        endcase
        return r;
    endfunction

    // Board is a permutation of 0..3 iff every slot is < 4 and all four values are seen.
    always_comb begin
        seen      = 4'b0000;
        all_small = 1'b1;
        blank     = 2'd0;
        for (int p = 0; p < 4; p++) begin
            logic [2:0] v;
            v = get_slot(board, 2'(p));
            if (v[2]) all_small = 1'b0;
            else      seen[v[1:0]] = 1'b1;
            if (v == 3'd0) blank = 2'(p);
        end
        perm_ok = all_small && (seen == 4'b1111);
    end

    // Slot p sits at row p[1], col p[0]; a move slides the blank toward move_dir.
    always_comb begin
        legal  = 1'b0;
        target = blank;
        case (move_dir)
            2'b00: begin legal = blank[1];  target = blank - 2'd2; end
            2'b01: begin legal = !blank[1]; target = blank + 2'd2; end
            2'b10: begin legal = blank[0];  target = blank - 2'd1; end
            default: begin legal = !blank[0]; target = blank + 2'd1; end
        endcase
        moved     = set_slot(set_slot(board, blank, get_slot(board, target)), target, 3'd0);
        count_inc = (move_count == MAX_CNT) ? move_count : move_count + 10'd1;
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board;
        count_d   = move_count;
        best_d    = best_moves;
        illegal_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            CHOSE_BOARD: begin
                if (confirm) begin
                    board_d = board_in;
                    count_d = 10'd0;
                    state_d = GAME_INITIAL;
                end
            end
            GAME_INITIAL: begin
                if (abort) begin
                    state_d = CHOSE_BOARD;
                end else if (!perm_ok) begin
                    err_d   = 1'b1;
                    state_d = CHOSE_BOARD;
                end else if (board == GOAL) begin
                    state_d = WINNED;
                    if (move_count < best_moves) best_d = move_count;
                end else begin
                    state_d = GAMING;
                end
            end
            GAMING: begin
                if (abort) begin
                    state_d = CHOSE_BOARD;
                end else if (move_valid) begin
                    if (legal) begin
                        board_d = moved;
                        count_d = count_inc;
                        if (moved == GOAL) begin
                            state_d = WINNED;
                            if (count_inc < best_moves) best_d = count_inc;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            default: begin
                if (confirm || abort) state_d = CHOSE_BOARD;
            end
        endcase
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q    <= CHOSE_BOARD;
            board      <= GOAL;
            move_count <= 10'd0;
            best_moves <= NO_BEST;
            illegal    <= 1'b0;
            board_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board      <= board_d;
            move_count <= count_d;
            best_moves <= best_d;
            illegal    <= illegal_d;
            board_err  <= err_d;
        end
    end

    assign game_status = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
module tb_game_controller;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [11:0] board_in;
    logic        confirm, abort, move_valid;
    logic [1:0]  move_dir;
    logic [1:0]  game_status;
    logic [11:0] board;
    logic [9:0]  move_count, best_moves;
    logic        illegal, board_err;

    int checks = 0;
    int errors = 0;

    game_controller dut (
        .clk_d(clk_d), .rst(rst), .board_in(board_in), .confirm(confirm), .abort(abort),
        .move_valid(move_valid), .move_dir(move_dir), .game_status(game_status),
        .board(board), .move_count(move_count), .best_moves(best_moves),
        .illegal(illegal), .board_err(board_err)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_d);
        #1;
    endtask

    task automatic pulse_confirm(input logic [11:0] b);
        board_in = b; confirm = 1'b1; cyc(); confirm = 1'b0;
    endtask

    task automatic move(input logic [1:0] d);
        move_dir = d; move_valid = 1'b1; cyc(); move_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_status"}, 32'(game_status), 32'h0);
        chk({tag, "_board"},  32'(board),       32'h053);
        chk({tag, "_count"},  32'(move_count),  32'h0);
        chk({tag, "_best"},   32'(best_moves),  32'h3FF);
        chk({tag, "_illegal"},32'(illegal),     32'h0);
        chk({tag, "_err"},    32'(board_err),   32'h0);
    endtask

    initial begin
        rst = 1'b1; board_in = '0; confirm = 0; abort = 0; move_valid = 0; move_dir = 0;
        #2;
        chk_reset_vals("rst0");
        cyc(); rst = 1'b0; cyc();

        // Single-move win from 1,0,2,3
        pulse_confirm(12'h213);
        chk("gi_status", 32'(game_status), 32'h2);
        chk("gi_board", 32'(board), 32'h213);
        cyc();
        chk("gaming_status", 32'(game_status), 32'h1);
        move(2'b10);
        chk("win1_board", 32'(board), 32'h053);
        chk("win1_count", 32'(move_count), 32'd1);
        chk("win1_status", 32'(game_status), 32'h3);
        chk("win1_best", 32'(best_moves), 32'd1);
        move(2'b00);
        chk("winned_noillegal", 32'(illegal), 32'h0);
        chk("winned_hold", 32'(board), 32'h053);
        pulse_confirm(12'h000);
        chk("winned_exit", 32'(game_status), 32'h0);

        // Illegal moves then a legal one
        pulse_confirm(12'h213); cyc();
        move(2'b11);
        chk("ill_right", 32'(illegal), 32'h1);
        chk("ill_right_board", 32'(board), 32'h213);
        move(2'b00);
        chk("ill_up", 32'(illegal), 32'h1);
        chk("ill_up_count", 32'(move_count), 32'd0);
        cyc();
        chk("ill_clear", 32'(illegal), 32'h0);
        move(2'b01);
        chk("down_board", 32'(board), 32'h2D0);
        chk("down_count", 32'(move_count), 32'd1);

        // abort beats move_valid
        abort = 1'b1; move_dir = 2'b00; move_valid = 1'b1; cyc();
        abort = 1'b0; move_valid = 1'b0;
        chk("abort_status", 32'(game_status), 32'h0);
        chk("abort_board", 32'(board), 32'h2D0);
        chk("abort_count", 32'(move_count), 32'd1);

        // Invalid boards: duplicate value, and a value above 3
        pulse_confirm(12'h013);
        chk("dup_gi", 32'(game_status), 32'h2);
        chk("dup_err_pre", 32'(board_err), 32'h0);
        cyc();
        chk("dup_err", 32'(board_err), 32'h1);
        chk("dup_status", 32'(game_status), 32'h0);
        cyc();
        chk("dup_err_clear", 32'(board_err), 32'h0);
        pulse_confirm(12'h853); cyc();
        chk("big_err", 32'(board_err), 32'h1);
        chk("big_status", 32'(game_status), 32'h0);

        // Three-move win leaves best at 1
        pulse_confirm(12'h2C2); cyc();
        move(2'b11);
        chk("w3_m1", 32'(board), 32'h2D0);
        move(2'b00);
        chk("w3_m2", 32'(board), 32'h213);
        move(2'b10);
        chk("w3_status", 32'(game_status), 32'h3);
        chk("w3_count", 32'(move_count), 32'd3);
        chk("w3_best", 32'(best_moves), 32'd1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("w3_abort_exit", 32'(game_status), 32'h0);

        // Saturation: 1030 alternating down/up moves
        pulse_confirm(12'h213); cyc();
        move_valid = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            move_dir = (i % 2 == 0) ? 2'b01 : 2'b00;
            cyc();
        end
        move_valid = 1'b0;
        chk("sat_count", 32'(move_count), 32'h3FF);
        chk("sat_board", 32'(board), 32'h213);
        move(2'b01);
        chk("sat_count2", 32'(move_count), 32'h3FF);
        chk("sat_board2", 32'(board), 32'h2D0);
        chk("sat_status", 32'(game_status), 32'h1);

        // Async reset mid-game at count 5
        abort = 1'b1; cyc(); abort = 1'b0;
        pulse_confirm(12'h213); cyc();
        move(2'b01); move(2'b00); move(2'b01); move(2'b00); move(2'b01);
        chk("pre_rst_count", 32'(move_count), 32'd5);
        chk("pre_rst_best", 32'(best_moves), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst1");
        cyc(); rst = 1'b0; cyc();

        // Goal board goes straight to WINNED with zero moves
        pulse_confirm(12'h053); cyc();
        chk("goal_status", 32'(game_status), 32'h3);
        chk("goal_best", 32'(best_moves), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
